// File: rtl/lock_controller_if.sv
// Keypad, comparator and status signals of the lock controller.
// master: the controller; slave: keypad/comparator/door side.
interface lock_controller_if;
  logic [3:0]  digit;
  logic        digit_valid;
  logic        enter;
  logic        set_req;
  logic        cmp_lock;
  logic [11:0] pass_in;
  logic [11:0] pass_set;
  logic        cmp_enb;
  logic        cmp_rst;
  logic        unlock;
  logic        alarm;
  logic [1:0]  digit_cnt;
  logic [3:0]  fail_cnt;

  modport master (
    input  digit, digit_valid, enter, set_req, cmp_lock,
    output pass_in, pass_set, cmp_enb, cmp_rst, unlock, alarm, digit_cnt, fail_cnt
  );

  modport slave (
    output digit, digit_valid, enter, set_req, cmp_lock,
    input  pass_in, pass_set, cmp_enb, cmp_rst, unlock, alarm, digit_cnt, fail_cnt
  );
endinterface

// File: rtl/lock_controller.sv
// Sequencing FSM for the digital lock: digit entry, compare strobe, unlock window, lockout.
// Define LOCK_PWCHANGE_EN to allow changing the stored password from the UNLOCKED state.
module lock_controller #(
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned UNLOCK_CYCLES  = 500,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter logic [11:0] DEFAULT_PASS   = 12'h123
) (
  input logic               clk,
  input logic               rst,
  lock_controller_if.master bus
);

  localparam int unsigned TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_ZERO     = {TW{1'b0}};
  localparam logic [TW-1:0] TMR_ONE      = TW'(1);
  localparam logic [3:0]    MAX_FAIL     = 4'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTRY    = 3'd1,
    CHECK    = 3'd2,
    SAMPLE   = 3'd3,
    UNLOCKED = 3'd4,
    LOCKOUT  = 3'd5
`ifdef LOCK_PWCHANGE_EN
    , SET_NEW = 3'd6
`endif
  } state_t;

  state_t        state_r;
  logic [11:0]   pass_in_r;
  logic [11:0]   pass_set_r;
  logic          cmp_enb_r;
  logic          cmp_rst_r;
  logic          unlock_r;
  logic          alarm_r;
  logic [1:0]    digit_cnt_r;
  logic [3:0]    fail_cnt_r;
  logic [TW-1:0] tmr_r;

  logic          digit_ok_s;
  logic [3:0]    fail_next_s;
  logic          fail_lock_s;

  // Digit acceptance and saturating failure count; enter always takes priority over a digit.
  always_comb begin
    digit_ok_s = bus.digit_valid && !bus.enter && (bus.digit <= 4'd9) && (digit_cnt_r < 2'd3);
    if (fail_cnt_r < MAX_FAIL) begin
      fail_next_s = fail_cnt_r + 4'd1;
    end else begin
      fail_next_s = fail_cnt_r;
    end
    fail_lock_s = (fail_next_s == MAX_FAIL);
  end

  // Main sequencing FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pass_in_r   <= 12'h000;
      pass_set_r  <= DEFAULT_PASS;
      cmp_enb_r   <= 1'b0;
      cmp_rst_r   <= 1'b1;
      unlock_r    <= 1'b0;
      alarm_r     <= 1'b0;
      digit_cnt_r <= 2'd0;
      fail_cnt_r  <= 4'd0;
      tmr_r       <= TMR_ZERO;
    end else begin
      cmp_enb_r <= 1'b0;
      cmp_rst_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (digit_ok_s) begin
            pass_in_r   <= {pass_in_r[7:0], bus.digit};
            digit_cnt_r <= digit_cnt_r + 2'd1;
            state_r     <= ENTRY;
          end
        end

        ENTRY: begin
          if (bus.enter) begin
            if (digit_cnt_r == 2'd3) begin
              cmp_enb_r <= 1'b1;
              state_r   <= CHECK;
            end else begin
              // Short entry is a failed attempt without consulting the comparator.
              fail_cnt_r  <= fail_next_s;
              pass_in_r   <= 12'h000;
              digit_cnt_r <= 2'd0;
              if (fail_lock_s) begin
                alarm_r <= 1'b1;
                tmr_r   <= LOCKOUT_LOAD;
                state_r <= LOCKOUT;
              end else begin
                state_r <= IDLE;
              end
            end
          end else if (digit_ok_s) begin
            pass_in_r   <= {pass_in_r[7:0], bus.digit};
            digit_cnt_r <= digit_cnt_r + 2'd1;
          end
        end

        CHECK: begin
          state_r <= SAMPLE;
        end

        SAMPLE: begin
          if (bus.cmp_lock) begin
            unlock_r   <= 1'b1;
            fail_cnt_r <= 4'd0;
            tmr_r      <= UNLOCK_LOAD;
            state_r    <= UNLOCKED;
          end else begin
            fail_cnt_r  <= fail_next_s;
            pass_in_r   <= 12'h000;
            digit_cnt_r <= 2'd0;
            if (fail_lock_s) begin
              alarm_r <= 1'b1;
              tmr_r   <= LOCKOUT_LOAD;
              state_r <= LOCKOUT;
            end else begin
              state_r <= IDLE;
            end
          end
        end

        UNLOCKED: begin
`ifdef LOCK_PWCHANGE_EN
          if (bus.set_req) begin
            unlock_r    <= 1'b0;
            pass_in_r   <= 12'h000;
            digit_cnt_r <= 2'd0;
            state_r     <= SET_NEW;
          end else
`endif
          if (tmr_r == TMR_ZERO) begin
            unlock_r    <= 1'b0;
            cmp_rst_r   <= 1'b1;
            pass_in_r   <= 12'h000;
            digit_cnt_r <= 2'd0;
            state_r     <= IDLE;
          end else begin
            tmr_r <= tmr_r - TMR_ONE;
          end
        end

        LOCKOUT: begin
          if (tmr_r == TMR_ZERO) begin
            alarm_r    <= 1'b0;
            fail_cnt_r <= 4'd0;
            cmp_rst_r  <= 1'b1;
            state_r    <= IDLE;
          end else begin
            tmr_r <= tmr_r - TMR_ONE;
          end
        end

`ifdef LOCK_PWCHANGE_EN
        SET_NEW: begin
          if (bus.enter) begin
            // Only a complete three-digit entry replaces the password.
            if (digit_cnt_r == 2'd3) begin
              pass_set_r <= pass_in_r;
            end else begin
              pass_set_r <= pass_set_r;
            end
            cmp_rst_r   <= 1'b1;
            pass_in_r   <= 12'h000;
            digit_cnt_r <= 2'd0;
            state_r     <= IDLE;
          end else if (digit_ok_s) begin
            pass_in_r   <= {pass_in_r[7:0], bus.digit};
            digit_cnt_r <= digit_cnt_r + 2'd1;
          end
        end
`endif

        default: begin
          unlock_r    <= 1'b0;
          alarm_r     <= 1'b0;
          pass_in_r   <= 12'h000;
          digit_cnt_r <= 2'd0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.pass_in   = pass_in_r;
  assign bus.pass_set  = pass_set_r;
  assign bus.cmp_enb   = cmp_enb_r;
  assign bus.cmp_rst   = cmp_rst_r;
  assign bus.unlock    = unlock_r;
  assign bus.alarm     = alarm_r;
  assign bus.digit_cnt = digit_cnt_r;
  assign bus.fail_cnt  = fail_cnt_r;

endmodule

// File: doc/lock_controller.md
# lock_controller

Sequencing FSM for the digital lock's 12-bit password comparator. It collects three BCD keypad digits into `pass_in` and strobes the comparator's `enb`. It then samples the comparator's `lock` result, holds the door unlocked for a timed window, and counts failed attempts into a timed lockout. The block owns the stored password `pass_set` and drives the comparator's `rst` to re-lock after every session.

## Interface
Parameters:
- `MAX_ATTEMPTS`, 3: consecutive failures that trigger lockout (1..15).
- `UNLOCK_CYCLES`, 500: clock cycles `unlock` stays high after a match (≥1).
- `LOCKOUT_CYCLES`, 1000: clock cycles of lockout (≥1).
- `DEFAULT_PASS`, 12'h123: `pass_set` value after reset (three BCD digits).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: synchronous active-high reset.
- `digit` in 4: keypad digit, BCD.
- `digit_valid` in 1: one-cycle strobe qualifying `digit`.
- `enter` in 1: one-cycle strobe submitting the entry.
- `set_req` in 1: one-cycle strobe requesting password change (only with macro).
- `cmp_lock` in 1: comparator match result.
- `pass_in` out 12: entered digits to comparator.
- `pass_set` out 12: stored password to comparator.
- `cmp_enb` out 1: registered one-cycle compare strobe.
- `cmp_rst` out 1: registered comparator reset.
- `unlock` out 1: door release.
- `alarm` out 1: high during lockout.
- `digit_cnt` out 2: digits currently buffered (0..3).
- `fail_cnt` out 4: consecutive failed attempts.

## Operation
- States: IDLE, ENTRY, CHECK, SAMPLE, UNLOCKED, LOCKOUT, SET_NEW (SET_NEW exists only with macro).
- Reset values: state IDLE, `pass_in`=0, `pass_set`=`DEFAULT_PASS`, `cmp_enb`=0, `cmp_rst`=1, `unlock`=0, `alarm`=0, `digit_cnt`=0, `fail_cnt`=0.
- Digit capture, applied in IDLE/ENTRY/SET_NEW:
  - Condition: `digit_valid` with `digit`≤9 and `digit_cnt`<3.
  - Action: `pass_in` <= {`pass_in[7:0]`, `digit`}; `digit_cnt`++.
  - First digit moves IDLE→ENTRY.
  - Digits >9 and a 4th digit are silently dropped.
- `enter` in ENTRY with `digit_cnt`=3 → CHECK.
- `enter` with `digit_cnt`<3 counts as a failure with no `cmp_enb` pulse.
- CHECK: `cmp_enb`=1 for exactly one cycle → SAMPLE.
- SAMPLE: `cmp_enb`=0; `cmp_lock` sampled at the end of the cycle.
  - Match (1) → UNLOCKED, `fail_cnt`=0.
  - No match (0) is a failure.
- Any failure:
  - `fail_cnt`++, `pass_in`=0, `digit_cnt`=0.
  - If the new `fail_cnt`=`MAX_ATTEMPTS` → LOCKOUT; else → IDLE.
- UNLOCKED:
  - `unlock`=1; a down-counter runs from `UNLOCK_CYCLES`.
  - At expiry: `unlock`=0, `cmp_rst` pulses 1 cycle, `pass_in`/`digit_cnt` clear → IDLE.
  - All inputs except `set_req` are ignored.
- LOCKOUT:
  - `alarm`=1; all inputs are ignored.
  - After `LOCKOUT_CYCLES`: `alarm`=0, `fail_cnt`=0, `cmp_rst` pulses 1 cycle → IDLE.
- Simultaneous `digit_valid` and `enter`: `enter` wins and the digit is dropped.
- `rst` in any state, mid-entry or mid-timer: all registers take reset values on the next edge.
- `fail_cnt` saturates at `MAX_ATTEMPTS`; it never wraps.

## Timing
- `cmp_rst` deasserts on the first edge after `rst` releases.
- `enter` sampled at edge E0 → CHECK at E0. `cmp_enb` is high from E0 to E1.
- `cmp_lock` is sampled at E2. `unlock` rises at E2, which is 2 cycles after `enter`.
- `unlock` high time is exactly `UNLOCK_CYCLES` cycles. `alarm` high time is exactly `LOCKOUT_CYCLES` cycles.
- `cmp_enb` and `cmp_rst` are glitch-free register outputs, never high together.

## Configuration
- `LOCK_PWCHANGE_EN` defined:
  - `set_req` in UNLOCKED → SET_NEW: `unlock`=0, buffer cleared.
  - In SET_NEW, `enter` with `digit_cnt`=3 writes `pass_in` to `pass_set`. `enter` with fewer digits discards the entry.
  - Either way: `cmp_rst` pulses and the FSM → IDLE, with no fail count.
- `LOCK_PWCHANGE_EN` undefined: `set_req` is ignored, `pass_set` is constant `DEFAULT_PASS`, and SET_NEW is absent.

## Test plan
- Reset, enter digits 1,2,3, `enter` (comparator model matches) → `cmp_enb` pulse 1 cycle after `enter`, `unlock`=1 two cycles after `enter`, held 500 cycles, then `cmp_rst` pulse and IDLE.
- Enter 4,5,6, `enter` ×3 with `MAX_ATTEMPTS`=3 → `fail_cnt` 1,2,3; `alarm`=1 for 1000 cycles, keypad ignored; afterwards `fail_cnt`=0.
- Digits 1,2 then `enter` → no `cmp_enb`, `fail_cnt`=1; digits 1,2,3,7 → `pass_in`=12'h123; digit 4'hA dropped.
- Same-cycle `digit_valid`+`enter` at `digit_cnt`=3 → compare of prior 3 digits, digit dropped; `rst` mid-UNLOCKED → `unlock`=0 next edge, `pass_set`=12'h123.
- With `LOCK_PWCHANGE_EN`: unlock, `set_req`, digits 9,8,7, `enter` → `pass_set`=12'h987; then 1,2,3 fails and 9,8,7 unlocks.
